// File: rtl/cbd_coeff_collector.sv
// cbd_coeff_collector: sequences cbd_sampler batches and packs the accepted
// lanes into consecutive mod-q polynomial coefficients in a coefficient RAM.
// All outputs are registered and line up with the FSM state they belong to:
// a coefficient write is visible in the DRAIN cycle that performs it, and
// poly_done is visible in the FIN cycle.
module cbd_coeff_collector #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 4,
  parameter int N_COEFF   = 256,
  parameter int ADDR_W    = 8,
  parameter int Q         = 3329,
  parameter int COEF_W    = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       poly_start,
  output logic                       busy,
  output logic                       samp_start,
  output logic                       samp_valid,
  input  logic                       samp_done,
  input  logic [LANES*CAND_BITS-1:0] samp_vals,
  input  logic [LANES-1:0]           samp_flags,
  output logic                       coef_wr_en,
  output logic [ADDR_W-1:0]          coef_addr,
  output logic [COEF_W-1:0]          coef_data,
  output logic                       poly_done
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // Index of the lowest set bit; 0 for an empty mask (callers never use it then).
  function automatic logic [LIDX_W-1:0] lowest_lane(input logic [LANES-1:0] m);
    lowest_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = LIDX_W'(i);
    end
  endfunction

  function automatic logic signed [CAND_BITS-1:0] lane_val(
    input logic [LANES*CAND_BITS-1:0] v,
    input logic [LIDX_W-1:0]          k
  );
    lane_val = v[k*CAND_BITS +: CAND_BITS];
  endfunction

  // Signed CBD value to [0, Q-1]: negatives wrap to Q+v in COEF_W+1 bits.
  function automatic logic [COEF_W-1:0] to_modq(input logic signed [CAND_BITS-1:0] v);
    logic [COEF_W:0] ext;
    ext = {{(COEF_W + 1 - CAND_BITS){v[CAND_BITS-1]}}, v};
    if (v[CAND_BITS-1]) to_modq = COEF_W'(ext + (COEF_W + 1)'(Q));
    else                to_modq = COEF_W'(ext);
  endfunction

  logic [2:0]                 state, state_nx;
  logic [ADDR_W-1:0]          cnt;
  logic [LANES-1:0]           pend_p1;
  logic [LANES*CAND_BITS-1:0] vals_p1;

  logic [LIDX_W-1:0] cur_k, nxt_k, first_k;
  logic [LANES-1:0]  pend_clr;
  logic [ADDR_W:0]   cnt_inc;
  logic              last_coef;

  // Lane selection and next-state decode.
  always_comb begin
    state_nx  = state;
    cur_k     = lowest_lane(pend_p1);
    pend_clr  = pend_p1 & ~(LANES'(1) << cur_k);
    nxt_k     = lowest_lane(pend_clr);
    first_k   = lowest_lane(samp_flags);
    cnt_inc   = {1'b0, cnt} + (ADDR_W + 1)'(1);
    last_coef = (cnt_inc == (ADDR_W + 1)'(N_COEFF));
    case (state)
      S_IDLE:  if (poly_start) state_nx = S_REQ;
      S_REQ:   state_nx = S_WAIT;
      S_WAIT:  if (samp_done) state_nx = (samp_flags == '0) ? S_REQ : S_DRAIN;
      S_DRAIN: begin
        if (last_coef)            state_nx = S_FIN;
        else if (pend_clr == '0)  state_nx = S_REQ;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: FSM, counters, pending mask and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pend_p1    <= '0;
      busy       <= 1'b0;
      samp_start <= 1'b0;
      samp_valid <= 1'b0;
      coef_wr_en <= 1'b0;
      coef_addr  <= '0;
      coef_data  <= '0;
      poly_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != S_IDLE);
      samp_start <= (state_nx == S_REQ);
      samp_valid <= (state_nx == S_REQ);
      coef_wr_en <= (state_nx == S_DRAIN);
      poly_done  <= (state_nx == S_FIN);
      case (state)
        S_IDLE: if (state_nx == S_REQ) cnt <= '0;
        S_WAIT: begin
          if (samp_done) begin
            pend_p1   <= samp_flags;
            coef_addr <= cnt;
            coef_data <= to_modq(lane_val(samp_vals, first_k));
          end
        end
        S_DRAIN: begin
          pend_p1 <= last_coef ? '0 : pend_clr;
          cnt     <= cnt_inc[ADDR_W-1:0];
          if (state_nx == S_DRAIN) begin
            coef_addr <= cnt_inc[ADDR_W-1:0];
            coef_data <= to_modq(lane_val(vals_p1, nxt_k));
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0 -> p1: sampler lane values captured with the done handshake.
  always_ff @(posedge clk) begin
    if (state == S_WAIT && samp_done) vals_p1 <= samp_vals;
  end

endmodule
